// File: rtl/neural_soc_key_pkg.sv
// Shared definitions for the key poller: key width, register address,
// counter widths and the poll FSM state encoding.
package neural_soc_key_pkg;

    localparam int unsigned KEY_W         = 4;
    localparam logic [1:0]  KEY_DATA_ADDR = 2'd0;
    localparam int unsigned DEB_CNT_W     = 4;
    localparam int unsigned RSP_CNT_W     = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StRsp    = 2'd2,
        StUpdate = 2'd3
    } poll_state_e;

endpackage

// File: rtl/neural_soc_key_debounce.sv
// One key bit: tracks how many consecutive polls returned the same sample and
// commits the level once it has been stable for DEBOUNCE_SAMPLES polls.
module neural_soc_key_debounce
    import neural_soc_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sample_en_i,
    input  logic sample_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [DEB_CNT_W-1:0] Target = DEB_CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [DEB_CNT_W-1:0] One    = DEB_CNT_W'(1);

    logic                 prev_q, prev_d;
    logic                 level_q, level_d;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sample_en_i) begin
            prev_d = sample_i;
            if (sample_i != prev_q) begin
                cnt_d = One;
            end else if (cnt_q != Target) begin
                cnt_d = cnt_q + One;
            end
            if ((cnt_d == Target) && (sample_i != level_q)) begin
                level_d = sample_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    // Keys are active-low: a press is the committed level falling.
    assign press_o = level_q & ~level_d;

endmodule

// File: rtl/neural_soc_key_poller.sv
// Periodically reads the key data register over Avalon-MM, debounces each key
// and reports press events through a valid/ready pending mask.
module neural_soc_key_poller
    import neural_soc_key_pkg::*;
#(
    parameter int unsigned POLL_CYCLES      = 50000,
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned RSP_TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_readdatavalid,
    output logic [KEY_W-1:0] key_state,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [KEY_W-1:0] evt_mask,
    output logic             rsp_err
);

    localparam int unsigned          PollW      = $clog2(POLL_CYCLES);
    localparam logic [PollW-1:0]     PollReload = PollW'(POLL_CYCLES - 1);
    localparam logic [RSP_CNT_W-1:0] TmoLast    = RSP_CNT_W'(RSP_TIMEOUT - 1);

    poll_state_e          state_q, state_d;
    logic [PollW-1:0]     poll_cnt_q, poll_cnt_d;
    logic [RSP_CNT_W-1:0] tmo_q, tmo_d;
    logic [KEY_W-1:0]     sample_q, sample_d;
    logic [KEY_W-1:0]     pending_q, pending_d;
    logic                 avm_read_q, avm_read_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 evt_valid_q, evt_valid_d;
    logic                 sample_en;
    logic [KEY_W-1:0]     press;
    logic [KEY_W-1:0]     level;
    logic                 unused_rdata;

    assign unused_rdata = ^avm_readdata[31:KEY_W];

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        tmo_d      = tmo_q;
        sample_d   = sample_q;
        avm_read_d = avm_read_q;
        rsp_err_d  = rsp_err_q;
        sample_en  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (poll_cnt_q == '0) begin
                    state_d    = StReq;
                    poll_cnt_d = PollReload;
                    avm_read_d = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q - 1'b1;
                end
            end
            StReq: begin
                if (!avm_waitrequest) begin
                    state_d    = StRsp;
                    avm_read_d = 1'b0;
                    tmo_d      = '0;
                end
            end
            StRsp: begin
                if (avm_readdatavalid) begin
                    sample_d = avm_readdata[KEY_W-1:0];
                    state_d  = StUpdate;
                end else if (tmo_q == TmoLast) begin
                    // Poll abandoned; debounce state is left untouched.
                    rsp_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StUpdate: begin
                sample_en = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        neural_soc_key_debounce #(
            .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
        ) u_debounce (
            .clk_i      (clk),
            .reset_i    (reset),
            .sample_en_i(sample_en),
            .sample_i   (sample_q[i]),
            .level_o    (level[i]),
            .press_o    (press[i])
        );
    end

    // Presses seen in the accept cycle survive the clear.
    always_comb begin
        pending_d = pending_q;
        if (evt_valid_q && evt_ready) begin
            pending_d = '0;
        end
        pending_d   = pending_d | press;
        evt_valid_d = |pending_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            poll_cnt_q  <= PollReload;
            tmo_q       <= '0;
            sample_q    <= '1;
            avm_read_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            tmo_q       <= tmo_d;
            sample_q    <= sample_d;
            avm_read_q  <= avm_read_d;
            rsp_err_q   <= rsp_err_d;
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
        end
    end

    assign avm_address = KEY_DATA_ADDR;
    assign avm_read    = avm_read_q;
    assign key_state   = level;
    assign evt_valid   = evt_valid_q;
    assign evt_mask    = pending_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_neural_soc_key_poller.sv
// Directed bench for the key poller with a small Avalon-MM slave driven from tasks.
module tb_neural_soc_key_poller;

    localparam int unsigned PollCycles = 10;
    localparam int unsigned DebSamples = 4;
    localparam int unsigned RspTimeout = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [3:0]  key_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_mask;
    logic        rsp_err;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          last_read_hi = 0;

    neural_soc_key_poller #(
        .POLL_CYCLES     (PollCycles),
        .DEBOUNCE_SAMPLES(DebSamples),
        .RSP_TIMEOUT     (RspTimeout)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .key_state        (key_state),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_mask         (evt_mask),
        .rsp_err          (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Serves one poll starting from IDLE; returns in the first IDLE cycle afterwards.
    task automatic serve(input logic [3:0] keys, input int waits, input bit respond,
                         input bit ready_upd, output int unsigned t_start);
        int n;
        int hi;
        n = 0;
        t_start = 0;
        while (avm_read !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (avm_read !== 1'b1) begin
            check_eq("read_start", {31'd0, avm_read}, 32'd1);
            return;
        end
        t_start = cyc;
        hi = 0;
        while (avm_read === 1'b1 && hi < 300) begin
            hi++;
            check_eq("avm_address", {30'd0, avm_address}, 32'd0);
            avm_waitrequest = (hi <= waits);
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        last_read_hi = hi;
        if (respond) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = {28'h5A5A5A5, keys};
            @(negedge clk);
            avm_readdatavalid = 1'b0;
            avm_readdata = '0;
            evt_ready = ready_upd;
            @(negedge clk);
            evt_ready = 1'b0;
        end else begin
            repeat (RspTimeout - 1) @(negedge clk);
            check_eq("err_before_tmo", {31'd0, rsp_err}, 32'd0);
            @(negedge clk);
            check_eq("err_after_tmo", {31'd0, rsp_err}, 32'd1);
            check_eq("read_low_tmo", {31'd0, avm_read}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t_rel;
        int unsigned t0;
        int unsigned t1;
        int unsigned t_idle;
        int          n;

        reset = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_key_state", {28'd0, key_state}, 32'h0000000F);
        check_eq("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
        check_eq("rst_evt_mask", {28'd0, evt_mask}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_avm_read", {31'd0, avm_read}, 32'd0);
        check_eq("rst_avm_address", {30'd0, avm_address}, 32'd0);

        reset = 1'b0;
        t_rel = cyc;
        serve(4'hF, 0, 1'b1, 1'b0, t0);
        check_eq("first_read_cycle", t0 - t_rel, 32'd10);
        serve(4'hF, 0, 1'b1, 1'b0, t1);
        check_eq("poll_spacing", t1 - t0, 32'd13);

        // Key1 bouncing every poll never settles.
        for (int i = 0; i < 10; i++) begin
            serve((i % 2 == 0) ? 4'hD : 4'hF, 0, 1'b1, 1'b0, t0);
            check_eq("bounce_key_state", {28'd0, key_state}, 32'h0000000F);
            check_eq("bounce_evt_valid", {31'd0, evt_valid}, 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            serve(4'hE, 0, 1'b1, 1'b0, t0);
            if (i < 3) check_eq("key0_early", {28'd0, key_state}, 32'h0000000F);
        end
        check_eq("key0_key_state", {28'd0, key_state}, 32'h0000000E);
        check_eq("key0_evt_valid", {31'd0, evt_valid}, 32'd1);
        check_eq("key0_evt_mask", {28'd0, evt_mask}, 32'h00000001);

        // Accept lands in the very UPDATE that detects key2.
        for (int i = 0; i < 4; i++) begin
            serve(4'hA, 0, 1'b1, (i == 3), t0);
            if (i == 2) check_eq("key2_pre_mask", {28'd0, evt_mask}, 32'h00000001);
        end
        check_eq("key2_evt_mask", {28'd0, evt_mask}, 32'h00000004);
        check_eq("key2_evt_valid", {31'd0, evt_valid}, 32'd1);
        check_eq("key2_key_state", {28'd0, key_state}, 32'h0000000A);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check_eq("accept_valid", {31'd0, evt_valid}, 32'd0);
        check_eq("accept_mask", {28'd0, evt_mask}, 32'd0);

        serve(4'hA, 7, 1'b1, 1'b0, t0);
        check_eq("wait_read_len", last_read_hi, 32'd8);
        check_eq("wait_key_state", {28'd0, key_state}, 32'h0000000A);

        serve(4'hA, 0, 1'b0, 1'b0, t0);
        t_idle = cyc;
        check_eq("tmo_key_state", {28'd0, key_state}, 32'h0000000A);
        check_eq("tmo_evt_valid", {31'd0, evt_valid}, 32'd0);
        serve(4'hF, 0, 1'b1, 1'b0, t1);
        check_eq("tmo_restart_gap", t1 - t_idle, 32'd10);
        for (int i = 0; i < 3; i++) serve(4'hF, 0, 1'b1, 1'b0, t0);
        check_eq("release_key_state", {28'd0, key_state}, 32'h0000000F);
        check_eq("release_no_event", {31'd0, evt_valid}, 32'd0);
        check_eq("rsp_err_sticky", {31'd0, rsp_err}, 32'd1);

        // Reset while the request is stalled, then a stray response in IDLE.
        avm_waitrequest = 1'b1;
        n = 0;
        while (avm_read !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_req_seen", {31'd0, avm_read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        t_rel = cyc;
        check_eq("mid_rst_read", {31'd0, avm_read}, 32'd0);
        check_eq("mid_rst_err", {31'd0, rsp_err}, 32'd0);
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'h0;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        serve(4'hF, 0, 1'b0, 1'b0, t0);
        check_eq("post_rst_first_read", t0 - t_rel, 32'd10);
        check_eq("stray_rsp_ignored", {28'd0, key_state}, 32'h0000000F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neural_soc_key_poller.md
NEURAL_SOC_KEY_POLLER -- requirements
Module: neural_soc_key_poller

Interface
REQ-001 Parameter POLL_CYCLES, default 50000, clk cycles between poll reads (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter DEBOUNCE_SAMPLES, default 4, consecutive identical samples required to accept a level; legal range 1..15.
REQ-003 Parameter RSP_TIMEOUT, default 255, maximum cycles spent waiting for readdatavalid; legal range 1..255.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 avm_address  output  2  Avalon-MM word address, constant 0 (key data register).
REQ-007 avm_read  output  1  Avalon-MM read request.
REQ-008 avm_waitrequest  input  1  fabric stall; request held while high.
REQ-009 avm_readdata  input  32  read data; only bits [3:0] used.
REQ-010 avm_readdatavalid  input  1  qualifies avm_readdata.
REQ-011 key_state  output  4  debounced key levels; keys are active-low, so 1 = released.
REQ-012 evt_valid  output  1  at least one press event pending.
REQ-013 evt_ready  input  1  consumer accepts the pending events.
REQ-014 evt_mask  output  4  keys pressed since the last accept.
REQ-015 rsp_err  output  1  sticky flag, set on response timeout.

Function
REQ-016 FSM states: IDLE, REQ, RSP, UPDATE.
REQ-017 IDLE: poll counter decrements each cycle; when it reaches 0, go to REQ and reload the counter with POLL_CYCLES-1.
REQ-018 REQ: avm_read=1 and avm_address=0; stay in REQ while avm_waitrequest=1; on the first cycle with avm_waitrequest=0, go to RSP.
REQ-019 RSP: avm_read=0; capture avm_readdata[3:0] when avm_readdatavalid=1 and go to UPDATE.
REQ-020 RSP timeout: after RSP_TIMEOUT cycles in RSP without readdatavalid, set rsp_err, discard the poll and go to IDLE; debounce state is unchanged.
REQ-021 UPDATE: one cycle; per bit, if the sample equals the previous sample, increment that bit's stable count (saturating at DEBOUNCE_SAMPLES); otherwise reset the count to 1; return to IDLE.
REQ-022 A key_state bit takes the sample value when that bit's stable count reaches DEBOUNCE_SAMPLES and the sample differs from key_state.
REQ-023 A press is a key_state bit changing 1->0; a release (0->1) generates no event.
REQ-024 Pending mask: pending |= presses each UPDATE; evt_mask = pending; evt_valid = (pending != 0).
REQ-025 Accept (evt_valid & evt_ready) clears pending, except presses detected in the same cycle, which remain pending.
REQ-026 At most one read is outstanding; a new poll never starts before UPDATE or timeout completes.
REQ-027 A poll interval that expires while a read is outstanding is not queued; the counter starts only on return to IDLE.
REQ-028 A readdatavalid arriving in IDLE or REQ is ignored.

Reset
REQ-029 On reset: state=IDLE, poll counter=POLL_CYCLES-1, avm_read=0, avm_address=0, key_state=4'hF, previous sample=4'hF, stable counts=0, pending=0, evt_valid=0, evt_mask=0, rsp_err=0.
REQ-030 Reset asserted mid-transaction drops the transaction in the next cycle; a late readdatavalid after reset is ignored per REQ-028.

Structure
REQ-031 Shared package neural_soc_key_pkg holds the FSM state encoding, KEY_W=4, and the key data register address constant 0.
REQ-032 One sub-module, neural_soc_key_debounce, holds the per-bit stable counter and level register; it is instantiated 4 times.

Verification
REQ-033 POLL_CYCLES=10, zero-wait slave: the first avm_read occurs in cycle 10 after reset release, and subsequent reads are spaced by POLL_CYCLES + transaction length.
REQ-034 Key0 held at 0 for 4 polls (DEBOUNCE_SAMPLES=4) -> key_state=4'hE after the 4th UPDATE; evt_valid=1, evt_mask=4'h1.
REQ-035 Key1 toggles 0/1 on alternate polls for 10 polls -> key_state stays 4'hF and evt_valid stays 0.
REQ-036 evt_ready=1 in the same cycle that a key2 press is detected while pending=4'h1 -> the next cycle shows evt_mask=4'h4 and evt_valid=1.
REQ-037 avm_waitrequest held high for 7 cycles -> avm_read stays high for 8 cycles, with address 0 throughout.
REQ-038 No readdatavalid for RSP_TIMEOUT=5 cycles -> rsp_err=1, FSM returns to IDLE, key_state unchanged; a later valid response updates normally.
